// File: rtl/banked_regs_file.sv
// Banked CPU register file: accumulator + regular banks, single-bit flags, write-source mux,
// same-cycle write bypass and a shadow context bank copied one entry per cycle.
module banked_regs_file #(
    parameter int WIDTH  = 8,
    parameter int ACC_N  = 6,
    parameter int REG_N  = 4,
    parameter int ADDR_W = 3,
    parameter int SRC_N  = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [ADDR_W-1:0]          read1,
    input  logic                       isReg1,
    input  logic [ADDR_W-1:0]          read2,
    input  logic                       isReg2,
    input  logic                       isReg3,
    input  logic                       isWrite,
    input  logic                       isRegW,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [SRC_N*WIDTH-1:0]     writeData,
    input  logic [$clog2(SRC_N+1)-1:0] dataSel,
    input  logic                       flipin,
    input  logic                       flagin,
    input  logic                       bitin,
    input  logic                       writeFlip,
    input  logic                       writeFlag,
    input  logic                       writeBit,
    input  logic                       ctxSave,
    input  logic                       ctxRestore,
    output logic [WIDTH-1:0]           reg1,
    output logic [WIDTH-1:0]           reg2,
    output logic [WIDTH-1:0]           reg3,
    output logic                       flipout,
    output logic                       flagout,
    output logic                       bitout,
    output logic                       busy
);
    localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
    localparam int DS_W   = $clog2(SRC_N + 1);
    localparam int N      = ACC_N + REG_N;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W:0]   ACC_LIM  = (ADDR_W+1)'(ACC_N);
    localparam logic [ADDR_W-1:0] ACC_LAST = ADDR_W'(ACC_N - 1);
    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(REG_N - 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE} seqState_t;

    seqState_t        state;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc   [ACC_N];
    logic [WIDTH-1:0] regs  [REG_N];
    logic [WIDTH-1:0] shAcc [ACC_N];
    logic [WIDTH-1:0] shReg [REG_N];

    logic [WIDTH-1:0] wData;
    logic             wrAcc, wrReg;

    assign busy = (state != IDLE);

    // dataSel 0 and anything above SRC_N both yield zero
    always_comb begin
        wData = '0;
        for (int k = 0; k < SRC_N; k++)
            if (dataSel == DS_W'(k + 1))
                wData = writeData[k*WIDTH +: WIDTH];
    end

    assign wrAcc = isWrite && !busy && !isRegW && ({1'b0, writeReg} < ACC_LIM);
    assign wrReg = isWrite && !busy && isRegW;

    function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] idx, input logic isReg);
        logic [WIDTH-1:0] v;
        v = '0;
        if (isReg) begin
            if (wrReg && writeReg[RIDX_W-1:0] == idx[RIDX_W-1:0]) v = wData;
            else                                                   v = regs[idx[RIDX_W-1:0]];
        end else if ({1'b0, idx} < ACC_LIM) begin
            if (wrAcc && writeReg == idx) v = wData;
            else                          v = acc[idx];
        end
        return v;
    endfunction

    always_comb begin
        reg1 = readPort(read1, isReg1);
        reg2 = readPort(read2, isReg2);
        reg3 = readPort(isReg3 ? REG_LAST : ACC_LAST, isReg3);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < ACC_N; i++) begin
                acc[i]   <= '0;
                shAcc[i] <= '0;
            end
            for (int j = 0; j < REG_N; j++) begin
                regs[j]  <= '0;
                shReg[j] <= '0;
            end
            state   <= IDLE;
            cnt     <= '0;
            flipout <= 1'b0;
            flagout <= 1'b0;
            bitout  <= 1'b0;
        end else begin
            if (writeFlip) flipout <= flipin;
            if (writeFlag) flagout <= flagin;
            if (writeBit)  bitout  <= bitin;

            // Bank writes and copy steps never coincide: writes are only accepted while idle
            for (int i = 0; i < ACC_N; i++) begin
                if (wrAcc && writeReg == ADDR_W'(i))
                    acc[i] <= wData;
                else if (state == RESTORE && cnt == CNT_W'(i))
                    acc[i] <= shAcc[i];
                if (state == SAVE && cnt == CNT_W'(i))
                    shAcc[i] <= acc[i];
            end
            for (int j = 0; j < REG_N; j++) begin
                if (wrReg && writeReg[RIDX_W-1:0] == RIDX_W'(j))
                    regs[j] <= wData;
                else if (state == RESTORE && cnt == CNT_W'(ACC_N + j))
                    regs[j] <= shReg[j];
                if (state == SAVE && cnt == CNT_W'(ACC_N + j))
                    shReg[j] <= regs[j];
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ctxSave)         state <= SAVE;
                    else if (ctxRestore) state <= RESTORE;
                end
                SAVE, RESTORE: begin
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banked_regs_file.sv
// Directed + randomized bench for banked_regs_file against a flat-array context model.
module tb_banked_regs_file;
    localparam int WIDTH = 8, ACC_N = 6, REG_N = 4, ADDR_W = 3, SRC_N = 4;
    localparam int N = ACC_N + REG_N;

    logic CLK = 1'b0;
    logic Reset;
    logic [ADDR_W-1:0] read1, read2, writeReg;
    logic isReg1, isReg2, isReg3, isWrite, isRegW;
    logic [SRC_N*WIDTH-1:0] writeData;
    logic [2:0] dataSel;
    logic flipin, flagin, bitin, writeFlip, writeFlag, writeBit, ctxSave, ctxRestore;
    logic [WIDTH-1:0] reg1, reg2, reg3;
    logic flipout, flagout, bitout, busy;

    always #5 CLK = ~CLK;

    banked_regs_file #(.WIDTH(WIDTH), .ACC_N(ACC_N), .REG_N(REG_N), .ADDR_W(ADDR_W), .SRC_N(SRC_N)) dut (
        .CLK(CLK), .Reset(Reset), .read1(read1), .isReg1(isReg1), .read2(read2), .isReg2(isReg2),
        .isReg3(isReg3), .isWrite(isWrite), .isRegW(isRegW), .writeReg(writeReg), .writeData(writeData),
        .dataSel(dataSel), .flipin(flipin), .flagin(flagin), .bitin(bitin), .writeFlip(writeFlip),
        .writeFlag(writeFlag), .writeBit(writeBit), .ctxSave(ctxSave), .ctxRestore(ctxRestore),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .flipout(flipout), .flagout(flagout), .bitout(bitout),
        .busy(busy));

    int vectors = 0, miscompares = 0;
    // Context as one flat list: acc[0..ACC_N-1] then regular[0..REG_N-1]
    int mAct[N], mSh[N];
    int mFlip, mFlag, mBit;
    int mMode;   // 0 idle, 1 saving, 2 restoring
    int mPos;
    bit chkEn;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int selData();
        int s = int'(dataSel);
        if (s >= 1 && s <= SRC_N) return int'((writeData >> ((s - 1) * WIDTH)) & 32'hFF);
        return 0;
    endfunction

    function automatic bit wrOk();
        return isWrite && mMode == 0 && (isRegW || int'(writeReg) < ACC_N);
    endfunction

    function automatic int wrEntry();
        return isRegW ? ACC_N + (int'(writeReg) % REG_N) : int'(writeReg);
    endfunction

    function automatic int expRead(input int idx, input bit isReg);
        int e;
        if (!isReg && idx >= ACC_N) return 0;
        e = isReg ? ACC_N + (idx % REG_N) : idx;
        if (wrOk() && wrEntry() == e) return selData();
        return mAct[e];
    endfunction

    task automatic tick();
        @(negedge CLK);
        if (chkEn) begin
            chk("reg1", reg1, expRead(int'(read1), isReg1));
            chk("reg2", reg2, expRead(int'(read2), isReg2));
            chk("reg3", reg3, expRead(isReg3 ? REG_N - 1 : ACC_N - 1, isReg3));
            chk("flipout", flipout, mFlip);
            chk("flagout", flagout, mFlag);
            chk("bitout", bitout, mBit);
            chk("busy", busy, (mMode != 0) ? 1 : 0);
        end
        @(posedge CLK);
        if (Reset) begin
            for (int i = 0; i < N; i++) begin mAct[i] = 0; mSh[i] = 0; end
            mFlip = 0; mFlag = 0; mBit = 0; mMode = 0; mPos = 0;
        end else begin
            if (writeFlip) mFlip = flipin;
            if (writeFlag) mFlag = flagin;
            if (writeBit)  mBit  = bitin;
            if (mMode == 0) begin
                if (wrOk()) mAct[wrEntry()] = selData();
                mPos = 0;
                if (ctxSave)         mMode = 1;
                else if (ctxRestore) mMode = 2;
            end else begin
                if (mMode == 1) mSh[mPos] = mAct[mPos];
                else            mAct[mPos] = mSh[mPos];
                mPos++;
                if (mPos == N) mMode = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        Reset = 0; isWrite = 0; isRegW = 0; writeReg = '0; writeData = '0; dataSel = '0;
        flipin = 0; flagin = 0; bitin = 0; writeFlip = 0; writeFlag = 0; writeBit = 0;
        ctxSave = 0; ctxRestore = 0;
    endtask

    task automatic wr(input bit isR, input int idx, input int val);
        isWrite = 1; isRegW = isR; writeReg = ADDR_W'(idx);
        writeData = 32'(val) << WIDTH; dataSel = 3'd2;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin tick(); n++; end
    endtask

    int n;

    initial begin
        idle();
        read1 = '0; read2 = '0; isReg1 = 0; isReg2 = 0; isReg3 = 0;
        chkEn = 0; Reset = 1; tick();
        chkEn = 1; tick();
        Reset = 0;
        for (int i = 0; i < 8; i++) begin
            read1 = 3'(i); isReg1 = 0; read2 = 3'(i); isReg2 = 1; isReg3 = i[0];
            tick();
        end

        // Bypass of source 2, then out-of-range dataSel stores zero
        writeData = 32'hA5 << 16; dataSel = 3'd3; isWrite = 1; isRegW = 0; writeReg = 3'd2;
        read1 = 3'd2; isReg1 = 0;
        #1 chk("bypass_a5", reg1, 'hA5);
        tick(); idle();
        #1 chk("acc2_held", reg1, 'hA5);
        tick();
        writeData = '1; dataSel = 3'd5; isWrite = 1; writeReg = 3'd2;
        tick(); idle();
        #1 chk("dsel_oob_zero", reg1, 0);
        tick();

        // Write to acc index 7 is dropped
        isWrite = 1; writeReg = 3'd7; dataSel = 3'd1; writeData = 32'h77; read1 = 3'd7;
        #1 chk("acc7_read", reg1, 0);
        tick(); idle();
        for (int i = 0; i < 8; i++) begin read1 = 3'(i); tick(); end

        // Save, clobber, restore
        for (int i = 0; i < ACC_N; i++) begin wr(0, i, i + 1); tick(); end
        for (int j = 0; j < REG_N; j++) begin wr(1, j, 'h10 + j); tick(); end
        idle(); ctxSave = 1; tick(); ctxSave = 0;
        waitIdle(n); chk("save_len", 32'(n), N);
        for (int i = 0; i < ACC_N; i++) begin wr(0, i, 'hFF); tick(); end
        for (int j = 0; j < REG_N; j++) begin wr(1, j, 'hFF); tick(); end
        idle(); ctxRestore = 1; tick(); ctxRestore = 0;
        waitIdle(n); chk("restore_len", 32'(n), N);
        for (int i = 0; i < ACC_N; i++) begin
            read1 = 3'(i); isReg1 = 0; read2 = 3'(i % REG_N); isReg2 = 1;
            #1 chk("restored_acc", reg1, i + 1);
            chk("restored_reg", reg2, 'h10 + (i % REG_N));
            tick();
        end

        // Writes and requests while busy are dropped; flag still lands
        ctxSave = 1; tick(); ctxSave = 0; tick();
        wr(1, 0, 'h33); ctxRestore = 1; writeFlag = 1; flagin = 1; read1 = 3'd0; isReg1 = 1;
        #1 chk("no_bypass_busy", reg1, 'h10);
        tick(); idle();
        waitIdle(n);
        #1 chk("blocked_write", reg1, 'h10);
        chk("flag_set", flagout, 1);
        chk("restore_ignored", busy, 0);

        // Reset in the 4th restore cycle abandons the copy
        ctxRestore = 1; tick(); ctxRestore = 0;
        for (int k = 0; k < 3; k++) tick();
        Reset = 1; tick(); Reset = 0;
        chk("reset_busy", busy, 0);
        chk("reset_reg1", reg1, 0);
        ctxSave = 1; tick(); ctxSave = 0;
        chk("save_reaccept", busy, 1);
        waitIdle(n);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            read1 = 3'($urandom_range(0, 7)); isReg1 = 1'($urandom);
            read2 = 3'($urandom_range(0, 7)); isReg2 = 1'($urandom);
            isReg3 = 1'($urandom);
            isWrite = 1'($urandom); isRegW = 1'($urandom);
            writeReg = 3'($urandom_range(0, 7)); writeData = $urandom;
            dataSel = 3'($urandom_range(0, 7));
            flipin = 1'($urandom); flagin = 1'($urandom); bitin = 1'($urandom);
            writeFlip = 1'($urandom); writeFlag = 1'($urandom); writeBit = 1'($urandom);
            ctxSave = ($urandom_range(0, 19) == 0);
            ctxRestore = ($urandom_range(0, 14) == 0);
            Reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
